// File: rtl/maxpool_row_ctrl_if.sv
// Stream bundle for the row-pair max-pooling sequencer.
// Carries the raster pixel input stream and the pooled-row output stream.
//   in_valid/in_ready/in_data        : one pixel of D channels per beat
//   out_valid/out_ready/out_data     : one pooled row of W/2 pixels
//   out_last                         : final pooled row of the frame
// The slave modport is the controller's view, master is the environment's.
interface maxpool_row_ctrl_if #(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int W         = 92
);
  logic                              in_valid;
  logic                              in_ready;
  logic [D*DATA_BITS-1:0]            in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [(W/2)*D*DATA_BITS-1:0]      out_data;
  logic                              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool_row_ctrl.sv
// Row-pair 2x2/stride-2 max-pooling sequencer.
// Collects two raster rows into a pair buffer, presents the pooled row
// (W/2 pixels of D channels) until the downstream accepts it, then moves on.
// An odd trailing row is consumed and dropped.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : frame start request, honoured only when idle
//   bus          : input pixel stream and pooled-row output stream
//   busy         : frame in progress (start accepted until the done cycle)
//   done         : one-cycle end-of-frame pulse

// Combinational 2x2 max over a buffered row pair.
// pair_i holds the even row in words [0, D*W) and the odd row in [D*W, 2*D*W),
// word index c*W+x within each row; pool_o word index is c*(W/2)+x.
module max_pooling_single #(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int W         = 92
) (
  input  logic [2*D*W*DATA_BITS-1:0]     pair_i,
  output logic [(W/2)*D*DATA_BITS-1:0]   pool_o
);
  // On a tie the first operand is kept.
  function automatic logic [DATA_BITS-1:0] max2(input logic [DATA_BITS-1:0] a,
                                                input logic [DATA_BITS-1:0] b);
    return (b > a) ? b : a;
  endfunction

  for (genvar c = 0; c < D; c++) begin : g_ch
    for (genvar x = 0; x < W/2; x++) begin : g_px
      logic [DATA_BITS-1:0] top_s;
      logic [DATA_BITS-1:0] bot_s;
      assign top_s = max2(pair_i[(c*W + 2*x)*DATA_BITS +: DATA_BITS],
                          pair_i[(c*W + 2*x + 1)*DATA_BITS +: DATA_BITS]);
      assign bot_s = max2(pair_i[((D+c)*W + 2*x)*DATA_BITS +: DATA_BITS],
                          pair_i[((D+c)*W + 2*x + 1)*DATA_BITS +: DATA_BITS]);
      assign pool_o[(c*(W/2) + x)*DATA_BITS +: DATA_BITS] = max2(top_s, bot_s);
    end
  end
endmodule

module maxpool_row_ctrl #(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int W         = 92,
  parameter int H         = 92
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  maxpool_row_ctrl_if.slave    bus,
  output logic                 busy,
  output logic                 done
);
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int NP = H / 2;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NP - 1);
  localparam bit H_ODD = ((H % 2) == 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL0   = 3'd1,
    S_FILL1   = 3'd2,
    S_OUT     = 3'd3,
    S_DISCARD = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                        state_q, state_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [PW-1:0]                 p_q, p_d;
  logic [2*D*W*DATA_BITS-1:0]    pair_q, pair_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          in_xfer_s;
  logic                          out_xfer_s;
  logic                          x_wrap_s;
  int                            row_off_s;
  logic [(W/2)*D*DATA_BITS-1:0]  pool_s;

  // Pooling datapath on the stable pair buffer.
  max_pooling_single #(
    .DATA_BITS (DATA_BITS),
    .D         (D),
    .W         (W)
  ) u_pool (
    .pair_i (pair_q),
    .pool_o (pool_s)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = pool_s;
  assign busy          = busy_q;
  assign done          = done_q;

  // Next-state, counters, pair-buffer writes and registered handshake outputs.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    p_d        = p_q;
    pair_d     = pair_q;
    in_xfer_s  = bus.in_valid & in_ready_q;
    out_xfer_s = out_valid_q & bus.out_ready;
    x_wrap_s   = (x_q == X_LAST);
    row_off_s  = (state_q == S_FILL1) ? D*W : 0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL0, S_FILL1, S_DISCARD: begin
        // DISCARD shares the column counter but never touches the buffer.
        if (in_xfer_s && (state_q != S_DISCARD)) begin
          for (int c = 0; c < D; c++) begin
            pair_d[(row_off_s + c*W + int'(x_q))*DATA_BITS +: DATA_BITS] =
              bus.in_data[c*DATA_BITS +: DATA_BITS];
          end
        end else begin
          pair_d = pair_q;
        end
        if (in_xfer_s) begin
          if (x_wrap_s) begin
            x_d = '0;
            if (state_q == S_FILL0) begin
              state_d = S_FILL1;
            end else if (state_q == S_FILL1) begin
              state_d = S_OUT;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            x_d = x_q + XW'(1'b1);
          end
        end else begin
          x_d = x_q;
        end
      end
      S_OUT: begin
        // in_ready is low here, so the buffer (and out_data) holds until accepted.
        if (out_xfer_s) begin
          if (!out_last_q) begin
            p_d     = p_q + PW'(1'b1);
            state_d = S_FILL0;
          end else if (H_ODD) begin
            state_d = S_DISCARD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        x_d     = '0;
        p_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    in_ready_d  = (state_d == S_FILL0) || (state_d == S_FILL1) || (state_d == S_DISCARD);
    out_valid_d = (state_d == S_OUT);
    out_last_d  = (state_d == S_OUT) && (p_d == P_LAST);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State, counters, pair buffer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      p_q         <= '0;
      pair_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      p_q         <= p_d;
      pair_q      <= pair_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_maxpool_row_ctrl.sv
// Self-checking bench for maxpool_row_ctrl: W=4, D=1, DATA_BITS=8.
// dut_a runs H=4 frames, dut_b runs H=5 frames; sel steers shared stimulus.
module tb_maxpool_row_ctrl;
  localparam int DB = 8;
  localparam int DC = 1;
  localparam int WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sel;
  logic        start_s, in_valid_s, out_ready_s;
  logic [7:0]  in_data_s;
  logic        start_a, start_b, busy_a, busy_b, done_a, done_b;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m, done_m;
  logic [15:0] out_data_m;

  maxpool_row_ctrl_if #(.DATA_BITS(DB), .D(DC), .W(WW)) bus_a ();
  maxpool_row_ctrl_if #(.DATA_BITS(DB), .D(DC), .W(WW)) bus_b ();

  assign start_a         = start_s & ~sel;
  assign start_b         = start_s & sel;
  assign bus_a.in_valid  = in_valid_s & ~sel;
  assign bus_b.in_valid  = in_valid_s & sel;
  assign bus_a.in_data   = in_data_s;
  assign bus_b.in_data   = in_data_s;
  assign bus_a.out_ready = out_ready_s & ~sel;
  assign bus_b.out_ready = out_ready_s & sel;

  assign in_ready_m  = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign out_valid_m = sel ? bus_b.out_valid : bus_a.out_valid;
  assign out_last_m  = sel ? bus_b.out_last  : bus_a.out_last;
  assign out_data_m  = sel ? bus_b.out_data  : bus_a.out_data;
  assign busy_m      = sel ? busy_b : busy_a;
  assign done_m      = sel ? done_b : done_a;

  maxpool_row_ctrl #(.DATA_BITS(DB), .D(DC), .W(WW), .H(4)) dut_a (
    .clk (clk), .reset_n (reset_n), .start (start_a), .bus (bus_a),
    .busy (busy_a), .done (done_a)
  );

  maxpool_row_ctrl #(.DATA_BITS(DB), .D(DC), .W(WW), .H(5)) dut_b (
    .clk (clk), .reset_n (reset_n), .start (start_b), .bus (bus_b),
    .busy (busy_b), .done (done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  bit seen99 = 1'b0;

  always @(negedge clk) begin
    if (done_a || done_b) done_seen <= done_seen + 1;
    if (out_valid_m && ((out_data_m[7:0] == 8'd99) || (out_data_m[15:8] == 8'd99))) seen99 <= 1'b1;
  end

  typedef struct {
    logic [3:0][3:0][7:0] pix;      // pix[row][col]
    logic [1:0][15:0]     exp_row;  // pooled row per pair, pixel 0 in [7:0]
    int                   stall;
    bit                   rnd;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [3:0][7:0] row(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready_m, 0);
    chk({tag, "_out_valid"}, out_valid_m, 0);
    chk({tag, "_out_last"}, out_last_m, 0);
    chk({tag, "_busy"}, busy_m, 0);
    chk({tag, "_done"}, done_m, 0);
    chk({tag, "_out_data"}, out_data_m, 0);
  endtask

  task automatic do_start();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("busy_after_start", busy_m, 1);
    chk("in_ready_after_start", in_ready_m, 1);
  endtask

  task automatic send_pix(input logic [7:0] v, input bit rnd, input bit last_of_pair);
    int guard = 0;
    bit sent = 1'b0;
    while (!sent && guard < 100) begin
      if (rnd && ($urandom_range(1, 0) == 0)) begin
        in_valid_s = 1'b0;
        tick();
        guard++;
      end else begin
        in_valid_s = 1'b1;
        in_data_s  = v;
        if (in_ready_m) begin
          if (last_of_pair) chk("out_valid_before_last_pixel", out_valid_m, 0);
          tick();
          in_valid_s = 1'b0;
          sent = 1'b1;
        end else begin
          tick();
          guard++;
        end
      end
    end
    if (!sent) chk("send_timeout", 0, 1);
  endtask

  task automatic take_row(input logic [15:0] exp, input bit last_exp, input int stall);
    int guard = 0;
    // Junk on the input while the row is pending must not reach the buffer.
    in_valid_s = 1'b1;
    in_data_s  = 8'hEE;
    while (!out_valid_m && guard < 20) begin
      tick();
      guard++;
    end
    chk("out_valid_latency", guard, 0);
    for (int s = 0; s < stall; s++) begin
      out_ready_s = 1'b0;
      chk("hold_data", out_data_m, exp);
      chk("hold_valid", out_valid_m, 1);
      chk("hold_last", out_last_m, last_exp);
      chk("hold_in_ready", in_ready_m, 0);
      tick();
    end
    out_ready_s = 1'b1;
    chk("row_data", out_data_m, exp);
    chk("row_last", out_last_m, last_exp);
    chk("in_ready_in_out", in_ready_m, 0);
    tick();
    out_ready_s = 1'b0;
    in_valid_s  = 1'b0;
    chk("valid_after_xfer", out_valid_m, 0);
  endtask

  task automatic run_frame(input vec_t v, input bit odd_h, input bit mid_start);
    int d0 = done_seen;
    do_start();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 4; c++) begin
          send_pix(v.pix[2*p + r][c], v.rnd, (r == 1) && (c == 3));
          if (mid_start && (p == 0) && (r == 1) && (c == 0)) begin
            start_s = 1'b1;
            tick();
            start_s = 1'b0;
          end
        end
      end
      chk("busy_mid_frame", busy_m, 1);
      take_row(v.exp_row[p], p == 1, v.stall);
    end
    if (odd_h) begin
      chk("discard_in_ready", in_ready_m, 1);
      for (int c = 0; c < 4; c++) begin
        send_pix(8'd99, 1'b0, 1'b0);
        chk("discard_no_out", out_valid_m, 0);
      end
      chk("in_ready_after_discard", in_ready_m, 0);
    end
    chk("done_pulse", done_m, 1);
    chk("busy_in_done", busy_m, 1);
    tick();
    chk("done_clear", done_m, 0);
    chk("busy_clear", busy_m, 0);
    chk("done_count", done_seen - d0, 1);
  endtask

  initial begin
    int d0;
    reset_n = 1'b0; sel = 1'b0; start_s = 1'b0;
    in_valid_s = 1'b0; in_data_s = 8'd0; out_ready_s = 1'b0;

    vecs[0].pix[0] = row(8'd1, 8'd5, 8'd2, 8'd0);
    vecs[0].pix[1] = row(8'd3, 8'd4, 8'd9, 8'd7);
    vecs[0].pix[2] = row(8'd8, 8'd8, 8'd1, 8'd2);
    vecs[0].pix[3] = row(8'd0, 8'd6, 8'd3, 8'd3);
    vecs[0].exp_row[0] = {8'd9, 8'd5};
    vecs[0].exp_row[1] = {8'd3, 8'd8};
    vecs[0].stall = 0; vecs[0].rnd = 1'b0;
    vecs[1] = vecs[0]; vecs[1].stall = 5;
    vecs[2] = vecs[0]; vecs[2].rnd = 1'b1;
    vecs[3].pix[0] = row(8'd255, 8'd0, 8'd17, 8'd16);
    vecs[3].pix[1] = row(8'd254, 8'd1, 8'd16, 8'd17);
    vecs[3].pix[2] = row(8'd0, 8'd0, 8'd0, 8'd0);
    vecs[3].pix[3] = row(8'd0, 8'd0, 8'd128, 8'd127);
    vecs[3].exp_row[0] = {8'd17, 8'd255};
    vecs[3].exp_row[1] = {8'd128, 8'd0};
    vecs[3].stall = 2; vecs[3].rnd = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_a");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_in_ready", bus_b.in_ready, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0, 1'b0);

    // Odd frame height: fifth row consumed and dropped.
    sel = 1'b1;
    tick();
    run_frame(vecs[0], 1'b1, 1'b0);
    chk("no_99_out", seen99, 0);
    sel = 1'b0;
    tick();

    // Start during FILL1 is ignored; then a fresh frame.
    run_frame(vecs[3], 1'b0, 1'b1);
    tick();
    chk("idle_after_frame", busy_m, 0);
    run_frame(vecs[0], 1'b0, 1'b0);

    // Asynchronous abort on the third pixel of the second row.
    d0 = done_seen;
    do_start();
    for (int c = 0; c < 4; c++) send_pix(vecs[0].pix[0][c], 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) send_pix(vecs[0].pix[1][c], 1'b0, 1'b0);
    in_valid_s = 1'b1;
    in_data_s  = vecs[0].pix[1][2];
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    in_valid_s = 1'b0;
    tick();
    chk_reset_vals("abort_held");
    reset_n = 1'b1;
    tick();
    tick();
    chk("no_done_on_abort", done_seen - d0, 0);
    run_frame(vecs[0], 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
